// File: rtl/round_controller.sv
// Round controller: turns hit-detector level flags into single-frame bullet
// clear pulses. It also tracks per-player lives and post-hit invulnerability,
// and runs the IDLE/PLAY/OVER round state machine read by the renderer and
// the bullet logic.

// Invariant checker for the round controller's registered outputs.
module round_controller_chk #(
   parameter int unsigned LIVES = 3
) (
   input logic       frame_clk,
   input logic       Reset,
   input logic [3:0] p1_lives,
   input logic [3:0] p2_lives,
   input logic       game_active,
   input logic       game_over,
   input logic [1:0] winner
);

   // PLAY and OVER are mutually exclusive.
   a_state_excl : assert property (@(posedge frame_clk) disable iff (!Reset)
      !(game_active && game_over));

   // A winner is only ever reported while the round is over.
   a_winner_over : assert property (@(posedge frame_clk) disable iff (!Reset)
      (winner != 2'd0) |-> game_over);

   // Lives never exceed the per-round load value.
   a_p1_lives_max : assert property (@(posedge frame_clk) disable iff (!Reset)
      p1_lives <= 4'(LIVES));

   a_p2_lives_max : assert property (@(posedge frame_clk) disable iff (!Reset)
      p2_lives <= 4'(LIVES));

endmodule

module round_controller #(
   parameter int unsigned LIVES         = 3,
   parameter int unsigned INVULN_FRAMES = 60
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       player_1_hit,
   input  logic       player_2_hit,
   input  logic       armor_hit,
   input  logic       bullet_on_bullet_hit,
   output logic       bullet1_clear,
   output logic       bullet2_clear,
   output logic [3:0] p1_lives,
   output logic [3:0] p2_lives,
   output logic       p1_visible,
   output logic       p2_visible,
   output logic       game_active,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam logic [3:0] LIVES_LOAD = 4'(LIVES);
   localparam logic [7:0] CNT_LOAD   = 8'(INVULN_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } round_state_t;

   round_state_t state_r, state_s;

   // Previous-frame samples used for rising-edge detection
   logic start_prev_r;
   logic p1_hit_prev_r;
   logic p2_hit_prev_r;
   logic armor_prev_r;
   logic bob_prev_r;

   // Per-player life and invulnerability state
   logic [3:0] p1_lives_r, p1_lives_s;
   logic [3:0] p2_lives_r, p2_lives_s;
   logic [7:0] p1_cnt_r,   p1_cnt_s;
   logic [7:0] p2_cnt_r,   p2_cnt_s;
   logic [1:0] winner_r,   winner_s;

   // Registered output copies
   logic b1_clear_r, b1_clear_s;
   logic b2_clear_r, b2_clear_s;
   logic p1_vis_r,   p1_vis_s;
   logic p2_vis_r,   p2_vis_s;
   logic active_r,   active_s;
   logic over_r,     over_s;

   // Rising-edge strobes
   logic start_edge_s;
   logic p1_hit_edge_s;
   logic p2_hit_edge_s;
   logic armor_edge_s;
   logic bob_edge_s;

   assign start_edge_s  = start                & ~start_prev_r;
   assign p1_hit_edge_s = player_1_hit         & ~p1_hit_prev_r;
   assign p2_hit_edge_s = player_2_hit         & ~p2_hit_prev_r;
   assign armor_edge_s  = armor_hit            & ~armor_prev_r;
   assign bob_edge_s    = bullet_on_bullet_hit & ~bob_prev_r;

   // Edge-detect history; updates every frame regardless of round state.
   // start_prev resets high so a key held through reset must be released first.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         start_prev_r  <= 1'b1;
         p1_hit_prev_r <= 1'b0;
         p2_hit_prev_r <= 1'b0;
         armor_prev_r  <= 1'b0;
         bob_prev_r    <= 1'b0;
      end else begin
         start_prev_r  <= start;
         p1_hit_prev_r <= player_1_hit;
         p2_hit_prev_r <= player_2_hit;
         armor_prev_r  <= armor_hit;
         bob_prev_r    <= bullet_on_bullet_hit;
      end
   end

   // Round state, lives, counters and all registered outputs.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_r    <= ST_IDLE;
         p1_lives_r <= LIVES_LOAD;
         p2_lives_r <= LIVES_LOAD;
         p1_cnt_r   <= 8'd0;
         p2_cnt_r   <= 8'd0;
         winner_r   <= 2'd0;
         b1_clear_r <= 1'b0;
         b2_clear_r <= 1'b0;
         p1_vis_r   <= 1'b1;
         p2_vis_r   <= 1'b1;
         active_r   <= 1'b0;
         over_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         p1_lives_r <= p1_lives_s;
         p2_lives_r <= p2_lives_s;
         p1_cnt_r   <= p1_cnt_s;
         p2_cnt_r   <= p2_cnt_s;
         winner_r   <= winner_s;
         b1_clear_r <= b1_clear_s;
         b2_clear_r <= b2_clear_s;
         p1_vis_r   <= p1_vis_s;
         p2_vis_r   <= p2_vis_s;
         active_r   <= active_s;
         over_r     <= over_s;
      end
   end

   // Next-state logic: hit handling, invulnerability, game-end and restart.
   always_comb begin
      state_s    = state_r;
      p1_lives_s = p1_lives_r;
      p2_lives_s = p2_lives_r;
      p1_cnt_s   = p1_cnt_r;
      p2_cnt_s   = p2_cnt_r;
      winner_s   = winner_r;
      b1_clear_s = 1'b0;
      b2_clear_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            p1_lives_s = LIVES_LOAD;
            p2_lives_s = LIVES_LOAD;
            p1_cnt_s   = 8'd0;
            p2_cnt_s   = 8'd0;
            winner_s   = 2'd0;
            if (start_edge_s) begin
               state_s = ST_PLAY;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_PLAY: begin
            // Invulnerability counters tick down; a reload below overrides this.
            if (p1_cnt_r != 8'd0) begin
               p1_cnt_s = p1_cnt_r - 8'd1;
            end else begin
               p1_cnt_s = 8'd0;
            end
            if (p2_cnt_r != 8'd0) begin
               p2_cnt_s = p2_cnt_r - 8'd1;
            end else begin
               p2_cnt_s = 8'd0;
            end

            // P1 was hit by the P2 bullet: despawn that bullet.
            if (p1_hit_edge_s && (p1_cnt_r == 8'd0) && (p1_lives_r != 4'd0)) begin
               p1_lives_s = p1_lives_r - 4'd1;
               p1_cnt_s   = CNT_LOAD;
               b2_clear_s = 1'b1;
            end else begin
               p1_lives_s = p1_lives_r;
            end

            // P2 was hit by the P1 bullet: despawn that bullet.
            if (p2_hit_edge_s && (p2_cnt_r == 8'd0) && (p2_lives_r != 4'd0)) begin
               p2_lives_s = p2_lives_r - 4'd1;
               p2_cnt_s   = CNT_LOAD;
               b1_clear_s = 1'b1;
            end else begin
               p2_lives_s = p2_lives_r;
            end

            // Armor or bullet-on-bullet despawns both bullets.
            if (armor_edge_s || bob_edge_s) begin
               b1_clear_s = 1'b1;
               b2_clear_s = 1'b1;
            end else begin
               b1_clear_s = b1_clear_s;
            end

            // Game end is judged on the post-decrement lives.
            if ((p1_lives_s == 4'd0) && (p2_lives_s == 4'd0)) begin
               winner_s = 2'd3;
               state_s  = ST_OVER;
            end else if (p1_lives_s == 4'd0) begin
               winner_s = 2'd2;
               state_s  = ST_OVER;
            end else if (p2_lives_s == 4'd0) begin
               winner_s = 2'd1;
               state_s  = ST_OVER;
            end else begin
               state_s  = ST_PLAY;
            end
         end

         ST_OVER: begin
            if (start_edge_s) begin
               p1_lives_s = LIVES_LOAD;
               p2_lives_s = LIVES_LOAD;
               p1_cnt_s   = 8'd0;
               p2_cnt_s   = 8'd0;
               winner_s   = 2'd0;
               state_s    = ST_PLAY;
            end else begin
               state_s    = ST_OVER;
            end
         end

         default: begin
            state_s    = ST_IDLE;
            p1_lives_s = LIVES_LOAD;
            p2_lives_s = LIVES_LOAD;
            p1_cnt_s   = 8'd0;
            p2_cnt_s   = 8'd0;
            winner_s   = 2'd0;
         end
      endcase
   end

   // Status outputs derived from the upcoming state; sprites blink only in PLAY.
   always_comb begin
      active_s = (state_s == ST_PLAY);
      over_s   = (state_s == ST_OVER);
      if (state_s == ST_PLAY) begin
         p1_vis_s = (p1_cnt_s == 8'd0) | p1_cnt_s[2];
         p2_vis_s = (p2_cnt_s == 8'd0) | p2_cnt_s[2];
      end else begin
         p1_vis_s = 1'b1;
         p2_vis_s = 1'b1;
      end
   end

   assign bullet1_clear = b1_clear_r;
   assign bullet2_clear = b2_clear_r;
   assign p1_lives      = p1_lives_r;
   assign p2_lives      = p2_lives_r;
   assign p1_visible    = p1_vis_r;
   assign p2_visible    = p2_vis_r;
   assign game_active   = active_r;
   assign game_over     = over_r;
   assign winner        = winner_r;

   round_controller_chk #(
      .LIVES(LIVES)
   ) u_chk (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .p1_lives   (p1_lives_r),
      .p2_lives   (p2_lives_r),
      .game_active(active_r),
      .game_over  (over_r),
      .winner     (winner_r)
   );

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with LIVES=3, INVULN_FRAMES=60.
module tb_round_controller;

   logic       frame_clk;
   logic       Reset;
   logic       start;
   logic       player_1_hit;
   logic       player_2_hit;
   logic       armor_hit;
   logic       bullet_on_bullet_hit;
   logic       bullet1_clear;
   logic       bullet2_clear;
   logic [3:0] p1_lives;
   logic [3:0] p2_lives;
   logic       p1_visible;
   logic       p2_visible;
   logic       game_active;
   logic       game_over;
   logic [1:0] winner;

   int chk_cnt;
   int pass_cnt;

   round_controller #(
      .LIVES        (3),
      .INVULN_FRAMES(60)
   ) dut (
      .frame_clk           (frame_clk),
      .Reset               (Reset),
      .start               (start),
      .player_1_hit        (player_1_hit),
      .player_2_hit        (player_2_hit),
      .armor_hit           (armor_hit),
      .bullet_on_bullet_hit(bullet_on_bullet_hit),
      .bullet1_clear       (bullet1_clear),
      .bullet2_clear       (bullet2_clear),
      .p1_lives            (p1_lives),
      .p2_lives            (p2_lives),
      .p1_visible          (p1_visible),
      .p2_visible          (p2_visible),
      .game_active         (game_active),
      .game_over           (game_over),
      .winner              (winner)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input int obs, input int exp);
      chk_cnt++;
      if (obs == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one frame and settle just after the rising edge.
   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int exp_cnt;
      int exp_vis;
      chk_cnt  = 0;
      pass_cnt = 0;
      Reset = 1'b0;
      start = 1'b0;
      player_1_hit = 1'b0;
      player_2_hit = 1'b0;
      armor_hit = 1'b0;
      bullet_on_bullet_hit = 1'b0;

      // 1. Reset and start
      ticks(2);
      check("rst_p1_lives", p1_lives, 3);
      check("rst_p2_lives", p2_lives, 3);
      check("rst_active", game_active, 0);
      check("rst_over", game_over, 0);
      check("rst_winner", winner, 0);
      check("rst_p1_vis", p1_visible, 1);
      check("rst_p2_vis", p2_visible, 1);
      check("rst_clr1", bullet1_clear, 0);
      Reset = 1'b1;
      tick();
      check("idle_active", game_active, 0);
      start = 1'b1;
      tick();
      check("start_active", game_active, 1);
      start = 1'b0;
      tick();
      check("play_active", game_active, 1);

      // 2/3. Single hit, blinking, invulnerability window
      player_2_hit = 1'b1;
      tick();
      check("hit_p2_lives", p2_lives, 2);
      check("hit_clr1", bullet1_clear, 1);
      check("hit_clr2", bullet2_clear, 0);
      check("hit_p2_vis", p2_visible, 1);
      for (int k = 1; k <= 66; k++) begin
         player_2_hit = (k <= 4) || (k == 20) || (k == 21) || (k == 61) || (k == 62);
         tick();
         exp_cnt = (k < 61) ? (60 - k) : (60 - (k - 61));
         exp_vis = (exp_cnt == 0) ? 1 : ((exp_cnt >> 2) & 1);
         check("inv_p2_vis", p2_visible, exp_vis);
         check("inv_p2_lives", p2_lives, (k < 61) ? 2 : 1);
         check("inv_clr1", bullet1_clear, (k == 61) ? 1 : 0);
         check("inv_clr2", bullet2_clear, 0);
         check("inv_p1_lives", p1_lives, 3);
      end
      player_2_hit = 1'b0;

      // 4. Armor and bullet-on-bullet together
      armor_hit = 1'b1;
      bullet_on_bullet_hit = 1'b1;
      tick();
      check("armor_clr1", bullet1_clear, 1);
      check("armor_clr2", bullet2_clear, 1);
      check("armor_p1_lives", p1_lives, 3);
      check("armor_p2_lives", p2_lives, 1);
      tick();
      check("armor_clr1_end", bullet1_clear, 0);
      check("armor_clr2_end", bullet2_clear, 0);
      armor_hit = 1'b0;
      bullet_on_bullet_hit = 1'b0;
      tick();

      // 5. Game end: P1 loses
      player_1_hit = 1'b1;
      tick();
      check("p1_hit1_lives", p1_lives, 2);
      check("p1_hit1_clr2", bullet2_clear, 1);
      player_1_hit = 1'b0;
      ticks(60);
      player_1_hit = 1'b1;
      tick();
      check("p1_hit2_lives", p1_lives, 1);
      player_1_hit = 1'b0;
      ticks(60);
      player_1_hit = 1'b1;
      tick();
      check("end_p1_lives", p1_lives, 0);
      check("end_p2_lives", p2_lives, 1);
      check("end_over", game_over, 1);
      check("end_active", game_active, 0);
      check("end_winner", winner, 2);
      check("end_clr2", bullet2_clear, 1);
      check("end_p1_vis", p1_visible, 1);
      player_1_hit = 1'b0;
      player_2_hit = 1'b1;
      tick();
      check("over_ignore_p2", p2_lives, 1);
      check("over_ignore_clr1", bullet1_clear, 0);
      check("over_hold", game_over, 1);
      player_2_hit = 1'b0;
      start = 1'b1;
      tick();
      check("restart_p1", p1_lives, 3);
      check("restart_p2", p2_lives, 3);
      check("restart_active", game_active, 1);
      check("restart_winner", winner, 0);
      start = 1'b0;
      tick();

      // 5b. Simultaneous final hits -> draw
      player_1_hit = 1'b1;
      player_2_hit = 1'b1;
      tick();
      check("sim1_p1", p1_lives, 2);
      check("sim1_p2", p2_lives, 2);
      check("sim1_clr1", bullet1_clear, 1);
      check("sim1_clr2", bullet2_clear, 1);
      player_1_hit = 1'b0;
      player_2_hit = 1'b0;
      ticks(60);
      player_1_hit = 1'b1;
      player_2_hit = 1'b1;
      tick();
      check("sim2_p1", p1_lives, 1);
      check("sim2_p2", p2_lives, 1);
      player_1_hit = 1'b0;
      player_2_hit = 1'b0;
      ticks(60);
      player_1_hit = 1'b1;
      player_2_hit = 1'b1;
      tick();
      check("draw_p1", p1_lives, 0);
      check("draw_p2", p2_lives, 0);
      check("draw_winner", winner, 3);
      check("draw_over", game_over, 1);
      player_1_hit = 1'b0;
      player_2_hit = 1'b0;
      start = 1'b1;
      tick();
      check("restart2_p1", p1_lives, 3);
      check("restart2_active", game_active, 1);
      start = 1'b0;
      tick();

      // 6. Reset during PLAY, start held through reset release
      player_1_hit = 1'b1;
      tick();
      check("pre_rst_p1", p1_lives, 2);
      start = 1'b1;
      #2;
      Reset = 1'b0;
      #1;
      check("async_rst_p1", p1_lives, 3);
      check("async_rst_active", game_active, 0);
      check("async_rst_clr2", bullet2_clear, 0);
      check("async_rst_p1_vis", p1_visible, 1);
      tick();
      Reset = 1'b1;
      ticks(3);
      check("held_start_idle", game_active, 0);
      check("idle_hit_ignored", p1_lives, 3);
      check("idle_hit_noclr", bullet2_clear, 0);
      start = 1'b0;
      player_1_hit = 1'b0;
      tick();
      check("release_idle", game_active, 0);
      start = 1'b1;
      tick();
      check("repress_active", game_active, 1);
      start = 1'b0;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
